program_sequencer: RTL

Program-flow front end of the DSP core. Holds the 12-bit program counter that addresses instruction memory, resolves next-PC for sequential, branch, call, return and interrupt flow, and owns the 4-level hardware stack. The stack top is exported so the accumulator input path can load it (POP) and the accumulator low word can be pushed (PUSH). Sits directly upstream of instruction memory and the decoder; its `pc` output drives the instruction fetch.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/hw_stack.sv | 40 ++++
 rtl/program_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP core program-flow front end:
// flow opcode encoding and default geometry of the PC and hardware stack.
package dsp_pkg;

  localparam int              PC_W_DEF       = 12;
  localparam int              PC_STEP_DEF    = 2;
  localparam int              DEPTH_DEF      = 4;
  localparam logic [11:0]     INT_VECTOR_DEF = 12'h002;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_B     = 3'd1,
    OP_BCOND = 3'd2,
    OP_CALL  = 3'd3,
    OP_CALA  = 3'd4,
    OP_RET   = 3'd5,
    OP_PUSH  = 3'd6,
    OP_POP   = 3'd7
  } op_e;

endpackage

// File: rtl/hw_stack.sv
// DEPTH x PC_W shift stack: push when full drops the bottom entry,
// pop when empty re-reads the bottom entry (bottom is duplicated on pop).
module hw_stack
  import dsp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] value,
  output logic [PC_W-1:0] top,
  output logic [DW-1:0]   depth
);

  logic [PC_W-1:0] r_entry [DEPTH];
  logic [DW-1:0]   r_depth;

  // Entry shift register and saturating occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= {PC_W{1'b0}};
      r_depth <= {DW{1'b0}};
    end else if (push) begin
      r_entry[0] <= value;
      for (int i = 1; i < DEPTH; i++) r_entry[i] <= r_entry[i-1];
      if (r_depth != DW'(DEPTH)) r_depth <= r_depth + DW'(1);
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) r_entry[i] <= r_entry[i+1];
      if (r_depth != {DW{1'b0}}) r_depth <= r_depth - DW'(1);
    end
  end

  assign top   = r_entry[0];
  assign depth = r_depth;

endmodule

// File: rtl/program_sequencer.sv
// Program counter and next-PC resolution for sequential, branch, call,
// return and interrupt flow, with the hardware return stack.
module program_sequencer
  import dsp_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              PC_STEP    = PC_STEP_DEF,
  parameter int              DEPTH      = DEPTH_DEF,
  parameter logic [PC_W-1:0] INT_VECTOR = PC_W'(INT_VECTOR_DEF)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   op,
  input  logic                         cond,
  input  logic [PC_W-1:0]              target,
  input  logic [PC_W-1:0]              acc_lo,
  input  logic                         stall,
  input  logic                         int_req,
  input  logic                         int_en,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              stack_top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         int_ack
);

  logic [PC_W-1:0] r_pc;
  logic            r_int_ack;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_push_val;
  logic [PC_W-1:0] w_top;
  logic            w_push;
  logic            w_pop;
  logic            w_take_int;

  assign w_pc_inc   = r_pc + PC_W'(PC_STEP);
  assign w_take_int = int_req & int_en & ~stall;

  // Next-PC and stack control; stall holds everything, interrupt squashes op
  always_comb begin
    w_pc_next  = r_pc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_push_val = w_pc_inc;
    if (stall) begin
      w_pc_next = r_pc;
    end else if (w_take_int) begin
      w_push     = 1'b1;
      w_push_val = r_pc;  // squashed instruction re-executes on return
      w_pc_next  = INT_VECTOR;
    end else begin
      case (op_e'(op))
        OP_NEXT:  w_pc_next = w_pc_inc;
        OP_B:     w_pc_next = target;
        OP_BCOND: w_pc_next = cond ? target : w_pc_inc;
        OP_CALL: begin
          w_push    = 1'b1;
          w_pc_next = target;
        end
        OP_CALA: begin
          w_push    = 1'b1;
          w_pc_next = acc_lo;
        end
        OP_RET: begin
          w_pop     = 1'b1;
          w_pc_next = w_top;
        end
        OP_PUSH: begin
          w_push     = 1'b1;
          w_push_val = acc_lo;
          w_pc_next  = w_pc_inc;
        end
        OP_POP: begin
          w_pop     = 1'b1;
          w_pc_next = w_pc_inc;
        end
        default:  w_pc_next = w_pc_inc;
      endcase
    end
  end

  // PC register and interrupt acknowledge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= {PC_W{1'b0}};
      r_int_ack <= 1'b0;
    end else begin
      r_pc      <= w_pc_next;
      r_int_ack <= w_take_int;
    end
  end

  hw_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .value (w_push_val),
    .top   (w_top),
    .depth (depth)
  );

  assign pc        = r_pc;
  assign stack_top = w_top;
  assign int_ack   = r_int_ack;

endmodule
